// File: rtl/ddr3_traffic_gen.sv
// Start/done traffic engine for the ddr3_fsm request port and ddr3_ddl data streams:
// issues COUNT x BURSTS BL8 requests, streams seeded write data and checks read data.
module ddr3_traffic_gen #(
  parameter int WIDTH   = 32,
  parameter int ADDRS   = 25,
  parameter int REQID   = 4,
  parameter int BURSTS  = 2,
  parameter int COUNT   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [ADDRS-1:0]   base_i,
  input  logic [WIDTH-1:0]   seed_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               fail_o,
  output logic [15:0]        errcnt_o,
  output logic [ADDRS-1:0]   erradr_o,
  output logic               mem_wrreq_o,
  output logic               mem_wrlst_o,
  input  logic               mem_wrack_i,
  input  logic               mem_wrerr_i,
  output logic [REQID-1:0]   mem_wrtid_o,
  output logic [ADDRS-1:0]   mem_wradr_o,
  output logic               mem_rdreq_o,
  output logic               mem_rdlst_o,
  input  logic               mem_rdack_i,
  input  logic               mem_rderr_i,
  output logic [REQID-1:0]   mem_rdtid_o,
  output logic [ADDRS-1:0]   mem_rdadr_o,
  output logic               mem_wvalid_o,
  output logic               mem_wlast_o,
  input  logic               mem_wready_i,
  output logic [WIDTH/8-1:0] mem_wrmask_o,
  output logic [WIDTH-1:0]   mem_wrdata_o,
  input  logic               mem_rvalid_i,
  input  logic               mem_rlast_i,
  output logic               mem_rready_o,
  input  logic [WIDTH-1:0]   mem_rddata_i
);

  localparam int BEATS = 128 / WIDTH;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WREQ, WDAT, RREQ, RDAT, DONE} state_t;

  state_t           state, state_d;
  logic             verify_q;
  logic [ADDRS-1:0] base_q, adr_q, erradr_q;
  logic [WIDTH-1:0] seed_q, dat_q;
  logic [3:0]       b_q;
  logic [15:0]      t_q, errcnt_q;
  logic [KW-1:0]    k_q;
  logic [TW-1:0]    wdog_q;
  logic             fail_q;

  logic        last_beat, last_burst, last_req, active;
  logic        wbeat, rbeat, ack, progress, timeout, launch;
  logic        e_ack, e_data, e_last;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // Request n is tracked as (transaction t_q, burst b_q); dat_q walks seed + n*BEATS + k.
  assign last_beat  = (k_q == KW'(BEATS - 1));
  assign last_burst = (b_q == 4'(BURSTS - 1));
  assign last_req   = last_burst && (t_q == 16'(COUNT - 1));
  assign active     = (state == WREQ) || (state == WDAT) || (state == RREQ) || (state == RDAT);
  assign launch     = (state == IDLE) && start_i;
  assign wbeat      = (state == WDAT) && mem_wready_i;
  assign rbeat      = (state == RDAT) && mem_rvalid_i;
  assign ack        = ((state == WREQ) && mem_wrack_i) || ((state == RREQ) && mem_rdack_i);
  assign progress   = ack || wbeat || rbeat;
  assign timeout    = active && !progress && (wdog_q == TW'(TIMEOUT - 1));

  assign e_ack   = ((state == WREQ) && mem_wrack_i && mem_wrerr_i) ||
                   ((state == RREQ) && mem_rdack_i && mem_rderr_i);
  assign e_data  = rbeat && (mem_rddata_i != dat_q);
  assign e_last  = rbeat && (mem_rlast_i != last_beat);
  assign err_inc = 2'(e_ack) + 2'(e_data) + 2'(e_last) + 2'(timeout);
  assign err_sum = {1'b0, errcnt_q} + 17'(err_inc);

  assign mem_wradr_o  = adr_q;
  assign mem_rdadr_o  = adr_q;
  assign mem_wrtid_o  = t_q[REQID-1:0];
  assign mem_rdtid_o  = t_q[REQID-1:0];
  assign mem_wrdata_o = dat_q;
  assign mem_wrmask_o = {(WIDTH/8){mem_wvalid_o}};
  assign fail_o       = fail_q;
  assign errcnt_o     = errcnt_q;
  assign erradr_o     = erradr_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    mem_wrreq_o  = 1'b0;
    mem_wrlst_o  = 1'b0;
    mem_rdreq_o  = 1'b0;
    mem_rdlst_o  = 1'b0;
    mem_wvalid_o = 1'b0;
    mem_wlast_o  = 1'b0;
    mem_rready_o = 1'b0;
    unique case (state)
      IDLE: if (start_i) state_d = (mode_i == 2'b01) ? RREQ : WREQ;
      WREQ: begin
        busy_o      = 1'b1;
        mem_wrreq_o = 1'b1;
        mem_wrlst_o = last_burst;
        if (mem_wrack_i) state_d = WDAT;
      end
      WDAT: begin
        busy_o       = 1'b1;
        mem_wvalid_o = 1'b1;
        mem_wlast_o  = last_beat;
        if (mem_wready_i && last_beat)
          state_d = !last_req ? WREQ : (verify_q ? RREQ : DONE);
      end
      RREQ: begin
        busy_o      = 1'b1;
        mem_rdreq_o = 1'b1;
        mem_rdlst_o = last_burst;
        if (mem_rdack_i) state_d = RDAT;
      end
      RDAT: begin
        busy_o       = 1'b1;
        mem_rready_o = 1'b1;
        if (mem_rvalid_i && last_beat) state_d = last_req ? DONE : RREQ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
  end

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      verify_q <= 1'b0;
      base_q   <= '0;
      seed_q   <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      b_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
      wdog_q   <= '0;
      errcnt_q <= '0;
      fail_q   <= 1'b0;
      erradr_q <= '0;
    end else if (launch) begin
      verify_q <= mode_i[1];
      base_q   <= base_i;
      seed_q   <= seed_i;
      adr_q    <= base_i;
      dat_q    <= seed_i;
      b_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
      wdog_q   <= '0;
      errcnt_q <= '0;
      fail_q   <= 1'b0;
      erradr_q <= '0;
    end else begin
      if (progress || !active) wdog_q <= '0;
      else if (!timeout)       wdog_q <= wdog_q + TW'(1);

      if (wbeat || rbeat) begin
        dat_q <= dat_q + WIDTH'(1);
        if (!last_beat) begin
          k_q <= k_q + KW'(1);
        end else begin
          k_q <= '0;
          if (last_req) begin
            // Rewind so a following read-back phase starts again at request 0.
            adr_q <= base_q;
            dat_q <= seed_q;
            b_q   <= '0;
            t_q   <= '0;
          end else begin
            adr_q <= adr_q + ADDRS'(8);
            if (last_burst) begin
              b_q <= '0;
              t_q <= t_q + 16'd1;
            end else begin
              b_q <= b_q + 4'd1;
            end
          end
        end
      end

      if (err_inc != 2'd0) begin
        fail_q   <= 1'b1;
        errcnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (errcnt_q == 16'd0) erradr_q <= adr_q;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Bench for ddr3_traffic_gen: loopback memory responder, request/data scoreboard built
// from the address/ID/data formulas, and directed passes covering wrap, error and abort cases.
module tb_ddr3_traffic_gen;

  localparam int WIDTH   = 32;
  localparam int ADDRS   = 25;
  localparam int REQID   = 4;
  localparam int BURSTS  = 2;
  localparam int COUNT   = 20;
  localparam int TIMEOUT = 1023;
  localparam int BEATS   = 128 / WIDTH;
  localparam int NREQ    = COUNT * BURSTS;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start_i = 1'b0;
  logic [1:0]         mode_i = '0;
  logic [ADDRS-1:0]   base_i = '0;
  logic [WIDTH-1:0]   seed_i = '0;
  logic               busy_o, done_o, fail_o;
  logic [15:0]        errcnt_o;
  logic [ADDRS-1:0]   erradr_o;
  logic               mem_wrreq_o, mem_wrlst_o, mem_rdreq_o, mem_rdlst_o;
  logic               mem_wrack_i = 1'b0, mem_wrerr_i = 1'b0;
  logic               mem_rdack_i = 1'b0, mem_rderr_i = 1'b0;
  logic [REQID-1:0]   mem_wrtid_o, mem_rdtid_o;
  logic [ADDRS-1:0]   mem_wradr_o, mem_rdadr_o;
  logic               mem_wvalid_o, mem_wlast_o, mem_rready_o;
  logic               mem_wready_i = 1'b0;
  logic [WIDTH/8-1:0] mem_wrmask_o;
  logic [WIDTH-1:0]   mem_wrdata_o;
  logic               mem_rvalid_i = 1'b0, mem_rlast_i = 1'b0;
  logic [WIDTH-1:0]   mem_rddata_i = '0;

  always #5 clock = ~clock;

  ddr3_traffic_gen #(
    .WIDTH(WIDTH), .ADDRS(ADDRS), .REQID(REQID),
    .BURSTS(BURSTS), .COUNT(COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .mode_i(mode_i),
    .base_i(base_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .errcnt_o(errcnt_o), .erradr_o(erradr_o),
    .mem_wrreq_o(mem_wrreq_o), .mem_wrlst_o(mem_wrlst_o),
    .mem_wrack_i(mem_wrack_i), .mem_wrerr_i(mem_wrerr_i),
    .mem_wrtid_o(mem_wrtid_o), .mem_wradr_o(mem_wradr_o),
    .mem_rdreq_o(mem_rdreq_o), .mem_rdlst_o(mem_rdlst_o),
    .mem_rdack_i(mem_rdack_i), .mem_rderr_i(mem_rderr_i),
    .mem_rdtid_o(mem_rdtid_o), .mem_rdadr_o(mem_rdadr_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wlast_o(mem_wlast_o),
    .mem_wready_i(mem_wready_i), .mem_wrmask_o(mem_wrmask_o),
    .mem_wrdata_o(mem_wrdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rlast_i(mem_rlast_i), .mem_rready_o(mem_rready_o),
    .mem_rddata_i(mem_rddata_i)
  );

  typedef struct packed {
    logic [ADDRS-1:0] adr;
    logic [REQID-1:0] tid;
    logic             lst;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  req_t             exp_wr[$];
  req_t             exp_rd[$];
  beat_t            exp_wd[$];
  logic [ADDRS-1:0] log_wadr[$];
  logic [REQID-1:0] log_wtid[$];
  logic             log_wlst[$];
  logic [WIDTH-1:0] log_wdata[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Responder controls and bookkeeping.
  logic             hold_wrack = 1'b0;
  logic             gaps = 1'b0;
  int               wrerr_req = -1;
  int               rderr_req = -1;
  int               corrupt_beat = -1;
  int               wreq_idx = 0;
  int               rreq_idx = 0;
  int               rbeat_idx = 0;
  int               wk = 0;
  int               rk = 0;
  logic [ADDRS-1:0] wadr_cur = '0;
  logic [ADDRS-1:0] radr_cur = '0;
  logic [WIDTH-1:0] mem_store [logic [ADDRS+2:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Loopback memory: decides handshakes on the falling edge for the next rising edge.
  initial begin
    forever begin
      @(negedge clock);
      mem_wrack_i  = 1'b0;
      mem_wrerr_i  = 1'b0;
      mem_rdack_i  = 1'b0;
      mem_rderr_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rlast_i  = 1'b0;
      if (mem_wrreq_o && !hold_wrack && (!gaps || $urandom_range(0, 2) == 0)) begin
        mem_wrack_i = 1'b1;
        mem_wrerr_i = (wreq_idx == wrerr_req);
        wreq_idx++;
        wadr_cur = mem_wradr_o;
        wk = 0;
      end
      mem_wready_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (mem_wvalid_o && mem_wready_i) begin
        mem_store[{wadr_cur, 3'(wk)}] = mem_wrdata_o;
        wk++;
      end
      if (mem_rdreq_o && (!gaps || $urandom_range(0, 2) == 0)) begin
        mem_rdack_i = 1'b1;
        mem_rderr_i = (rreq_idx == rderr_req);
        rreq_idx++;
        radr_cur = mem_rdadr_o;
        rk = 0;
      end
      if (mem_rready_o && (!gaps || $urandom_range(0, 1) == 1)) begin
        mem_rvalid_i = 1'b1;
        mem_rddata_i = mem_store.exists({radr_cur, 3'(rk)}) ? mem_store[{radr_cur, 3'(rk)}] : '0;
        if (rbeat_idx == corrupt_beat) mem_rddata_i = mem_rddata_i + WIDTH'(1);
        mem_rlast_i = (rk == BEATS - 1);
        rk++;
        rbeat_idx++;
      end
    end
  end

  // Compare process: request fields and write data against the expected streams.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (done_o) done_cnt++;
      if (!reset) begin
        if (mem_wrreq_o) begin
          if (exp_wr.size() == 0) check("wrreq_unexpected", 64'(mem_wrreq_o), 64'd0);
          else begin
            check("wradr", 64'(mem_wradr_o), 64'(exp_wr[0].adr));
            check("wrtid", 64'(mem_wrtid_o), 64'(exp_wr[0].tid));
            check("wrlst", 64'(mem_wrlst_o), 64'(exp_wr[0].lst));
            if (mem_wrack_i) begin
              log_wadr.push_back(mem_wradr_o);
              log_wtid.push_back(mem_wrtid_o);
              log_wlst.push_back(mem_wrlst_o);
              void'(exp_wr.pop_front());
            end
          end
        end
        if (mem_wvalid_o) begin
          if (exp_wd.size() == 0) check("wvalid_unexpected", 64'(mem_wvalid_o), 64'd0);
          else begin
            check("wrdata", 64'(mem_wrdata_o), 64'(exp_wd[0].data));
            check("wlast", 64'(mem_wlast_o), 64'(exp_wd[0].last));
            check("wrmask", 64'(mem_wrmask_o), 64'((1 << (WIDTH / 8)) - 1));
            if (mem_wready_i) begin
              log_wdata.push_back(mem_wrdata_o);
              void'(exp_wd.pop_front());
            end
          end
        end
        if (mem_rdreq_o) begin
          if (exp_rd.size() == 0) check("rdreq_unexpected", 64'(mem_rdreq_o), 64'd0);
          else begin
            check("rdadr", 64'(mem_rdadr_o), 64'(exp_rd[0].adr));
            check("rdtid", 64'(mem_rdtid_o), 64'(exp_rd[0].tid));
            check("rdlst", 64'(mem_rdlst_o), 64'(exp_rd[0].lst));
            if (mem_rdack_i) void'(exp_rd.pop_front());
          end
        end
      end
    end
  end

  // Builds the expected streams from the request/data formulas, then pulses start.
  task automatic start_pass(input logic [1:0] mode, input logic [ADDRS-1:0] base,
                            input logic [WIDTH-1:0] seed);
    req_t  r;
    beat_t b;
    exp_wr.delete(); exp_wd.delete(); exp_rd.delete();
    log_wadr.delete(); log_wtid.delete(); log_wlst.delete(); log_wdata.delete();
    for (int n = 0; n < NREQ; n++) begin
      r.adr = base + ADDRS'(8 * n);
      r.tid = REQID'((n / BURSTS) % (1 << REQID));
      r.lst = ((n % BURSTS) == BURSTS - 1);
      if (mode != 2'b01) begin
        exp_wr.push_back(r);
        for (int k = 0; k < BEATS; k++) begin
          b.data = seed + WIDTH'(n * BEATS + k);
          b.last = (k == BEATS - 1);
          exp_wd.push_back(b);
        end
      end
      if (mode != 2'b00) exp_rd.push_back(r);
    end
    wreq_idx  = 0;
    rreq_idx  = 0;
    rbeat_idx = 0;
    @(negedge clock);
    start_i = 1'b1;
    mode_i  = mode;
    base_i  = base;
    seed_i  = seed;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic run_pass(input logic [1:0] mode, input logic [ADDRS-1:0] base,
                          input logic [WIDTH-1:0] seed, input int budget, output int cycles);
    int d0;
    d0 = done_cnt;
    start_pass(mode, base, seed);
    cycles = 1;
    while (!done_o && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    check("done_reached", 64'(done_o), 64'd1);
    @(negedge clock);
    #2;
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", 64'(busy_o), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},   64'(busy_o), 64'd0);
    check({tag, "_done"},   64'(done_o), 64'd0);
    check({tag, "_fail"},   64'(fail_o), 64'd0);
    check({tag, "_errcnt"}, 64'(errcnt_o), 64'd0);
    check({tag, "_erradr"}, 64'(erradr_o), 64'd0);
    check({tag, "_reqs"},   64'({mem_wrreq_o, mem_rdreq_o, mem_wvalid_o, mem_rready_o}), 64'd0);
    check({tag, "_wrdata"}, 64'(mem_wrdata_o), 64'd0);
    check({tag, "_wradr"},  64'(mem_wradr_o), 64'd0);
    check({tag, "_wrmask"}, 64'(mem_wrmask_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int d0;

    repeat (3) @(negedge clock);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Ideal loopback write-then-verify from base 0, seed 0.
    run_pass(2'b10, '0, '0, 5000, cyc);
    check("t1_fail", 64'(fail_o), 64'd0);
    check("t1_errcnt", 64'(errcnt_o), 64'd0);
    check("t1_drained", 64'(exp_wr.size() + exp_wd.size() + exp_rd.size()), 64'd0);
    check("t1_nbeats", 64'(log_wdata.size()), 64'(NREQ * BEATS));
    check("t1_adr0", 64'(log_wadr[0]), 64'd0);
    check("t1_adr1", 64'(log_wadr[1]), 64'd8);
    check("t1_lst0", 64'(log_wlst[0]), 64'd0);
    check("t1_lst1", 64'(log_wlst[1]), 64'd1);
    check("t1_tid1", 64'(log_wtid[1]), 64'd0);
    check("t1_data0", 64'(log_wdata[0]), 64'd0);
    check("t1_data7", 64'(log_wdata[7]), 64'd7);

    // Read beat 5 returns 6 instead of 5; it belongs to request 1 at 16 + 8.
    corrupt_beat = 5;
    run_pass(2'b10, 25'd16, '0, 5000, cyc);
    corrupt_beat = -1;
    check("t2_errcnt", 64'(errcnt_o), 64'd1);
    check("t2_fail", 64'(fail_o), 64'd1);
    check("t2_erradr", 64'(erradr_o), 64'd24);

    // Write acknowledge withheld: watchdog aborts the pass.
    hold_wrack = 1'b1;
    run_pass(2'b00, 25'h100, 32'h1234, 2000, cyc);
    check("t3_latency_near_1024", 64'(cyc >= 1020 && cyc <= 1030), 64'd1);
    check("t3_errcnt", 64'(errcnt_o), 64'd1);
    check("t3_erradr", 64'(erradr_o), 64'h100);
    check("t3_reqs_low", 64'({mem_wrreq_o, mem_rdreq_o, mem_wvalid_o, mem_rready_o}), 64'd0);
    hold_wrack = 1'b0;

    // Address, ID and data wrap-around.
    run_pass(2'b10, 25'h1FFFFF8, 32'hFFFFFFFE, 5000, cyc);
    check("t4_errcnt", 64'(errcnt_o), 64'd0);
    check("t4_nreq", 64'(log_wadr.size()), 64'(NREQ));
    check("t4_adr1_wrap", 64'(log_wadr[1]), 64'd0);
    check("t4_data2_wrap", 64'(log_wdata[2]), 64'd0);
    check("t4_tid30", 64'(log_wtid[30]), 64'd15);
    check("t4_tid32_wrap", 64'(log_wtid[32]), 64'd0);
    check("t4_drained", 64'(exp_wr.size() + exp_wd.size() + exp_rd.size()), 64'd0);

    // Random handshake gaps with a read error on request 3.
    gaps = 1'b1;
    rderr_req = 3;
    run_pass(2'b11, 25'h1000, 32'hA5A50000, 20000, cyc);
    gaps = 1'b0;
    rderr_req = -1;
    check("t5_errcnt", 64'(errcnt_o), 64'd1);
    check("t5_erradr", 64'(erradr_o), 64'h1018);
    check("t5_drained", 64'(exp_wr.size() + exp_wd.size() + exp_rd.size()), 64'd0);

    // Reset in the middle of the write data phase, then a fresh pass.
    wrerr_req = 0;
    d0 = done_cnt;
    start_pass(2'b00, 25'h200, 32'h1000);
    cyc = 0;
    while (!mem_wvalid_o && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("t6_in_wdat", 64'(mem_wvalid_o), 64'd1);
    check("t6_pre_fail", 64'(fail_o), 64'd1);
    wrerr_req = -1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_idle_zero("t6_reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    run_pass(2'b00, 25'h200, 32'h55, 5000, cyc);
    check("t6_first_data", 64'(log_wdata[0]), 64'h55);
    check("t6_first_adr", 64'(log_wadr[0]), 64'h200);
    check("t6_errcnt", 64'(errcnt_o), 64'd0);

    // Read-only check of what the previous pass wrote.
    run_pass(2'b01, 25'h200, 32'h55, 5000, cyc);
    check("t7_errcnt", 64'(errcnt_o), 64'd0);
    check("t7_fail", 64'(fail_o), 64'd0);
    check("t7_drained", 64'(exp_rd.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
